data_table_rd_arbiter: RTL
==========================

// Module: data_table_rd_arbiter
// PURPOSE
// Shares the single data-table RAM read port between N_REQ table engines (search, insert, delete).
// Grants one read per cycle, round-robin. Each requester has at most one read outstanding.
// Routes each returned word back to the requester that issued it, via a latency-matched ID pipe.
// Sits between the engines' rd_* interfaces and the RAM read port.
// PARAMETERS
// N_REQ        3                 number of requesters; index 0 = search engine
// A_WIDTH      TABLE_ADDR_WIDTH  RAM address width
// RD_LATENCY   2                 fixed RAM read latency in cycles, >=1
// PORTS
// clk_i             in   1              clock
// rst_i             in   1              reset; asynchronous, active-high
// req_i             in   N_REQ          requester i needs a read; must not depend on req_rd_avail_o
// req_rd_en_i       in   N_REQ          read strobe; honoured only when req_rd_avail_o[i]=1
// req_rd_addr_i     in   N_REQ*A_WIDTH  read address per requester
// req_rd_avail_o    out  N_REQ          requester i may strobe this cycle (one-hot or zero)
// req_rd_data_o     out  ram_data_t     returned word, broadcast to all requesters
// req_rd_data_val_o out  N_REQ          one-hot pulse: req_rd_data_o belongs to requester i
// ram_avail_i       in   1              RAM read port usable this cycle (low while a writer owns it)
// ram_rd_en_o       out  1              RAM read strobe
// ram_rd_addr_o     out  A_WIDTH        RAM read address
// ram_rd_data_i     in   ram_data_t     RAM read data, valid RD_LATENCY cycles after ram_rd_en_o
// BEHAVIOUR
// - Reset values: busy='0, rr_ptr=0, ID pipe invalid.
//   Outputs after reset: req_rd_avail_o='0, req_rd_data_val_o='0, ram_rd_en_o=0.
// - Eligibility: elig = req_i & ~busy (registered busy only).
// - grant = round-robin pick from elig. Search starts at rr_ptr and wraps N_REQ-1 -> 0.
// - req_rd_avail_o = ram_avail_i ? grant : '0.
// - Issue: issue_i = req_rd_avail_o[i] & req_rd_en_i[i].
//   ram_rd_en_o = |issue; ram_rd_addr_o = addr of the granted requester (mux, combinational).
// - ram_rd_addr_o holds the granted requester's address whenever any grant exists, even without an issue.
// - rd_en from a non-granted requester is ignored: no issue, no state change.
// - On issue by requester i: busy[i]<=1; rr_ptr<=(i+1) mod N_REQ.
// - With no issue, rr_ptr holds. A granted-but-idle requester keeps priority.
// - ID pipe: RD_LATENCY-stage shift register of {valid,id}, loaded with {ram_rd_en_o, granted id}.
// - At pipe output valid: req_rd_data_val_o[id]=1 (combinational from last stage), req_rd_data_o=ram_rd_data_i.
//   busy[id]<=0 at the next edge.
// - Latency: strobe in cycle t -> data_val in cycle t+RD_LATENCY -> earliest next avail to same requester at t+RD_LATENCY+1.
//   This no-bypass rule is deliberate: engines update their address on data_val.
// - Simultaneous events:
//   - return to requester A and issue by requester B in the same cycle: both processed.
//   - return and issue for the same id in one cycle: impossible by construction; assertion fires if seen.
// - ram_avail_i low: no avail, no issue, rr_ptr held. Returns still drain and clear busy.
// - req_i dropped while busy: the return is still delivered and busy cleared.
// - Reset mid-operation: in-flight IDs discarded. Data returning after reset produces no data_val.
// - Throughput: up to one read per cycle total. With N_REQ>=RD_LATENCY+1 busy requesters, the port stays fully used.
// STRUCTURE
// - hash_table package: add N_RD_CLIENTS=3, RAM_RD_LATENCY=2, typedef rd_client_id_t = logic [$clog2(N_RD_CLIENTS)-1:0].
// - ram_data_t is reused from the package.
// - Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant; combinational.
//   The pointer register stays in this block.
// - Everything else (busy vector, ID pipe, address mux) is inline.
// - SVA in translate_off:
//   - avail is one-hot0;
//   - data_val is one-hot0;
//   - no issue while busy;
//   - data_val only for a busy requester.
// TESTING
// 1 Single requester: req_i=001, rd_en on avail, addr=0x1A at t=5
//   -> ram_rd_en_o@5 addr 0x1A; data_val=001@7; avail=0 for t=6..7; avail=001@8.
// 2 Fairness: req_i=111 constant, all strobe on avail
//   -> issue order 0,1,2,0,1,2. Each requester gets its next grant only after its return.
// 3 ram_avail_i=0 for t=10..12, reads in flight
//   -> no ram_rd_en_o t=10..12; pending returns still pulse data_val; rr_ptr unchanged.
// 4 Granted req 1 holds rd_en=0 for 3 cycles; req 2 also pending
//   -> avail stays 010; req 2 is not served until req 1 issues.
// 5 Back-to-back streams from reqs 0 and 2, RD_LATENCY=2
//   -> data tagged to the correct requester every cycle; no cross-delivery. Check with a scoreboard on address->data.
// 6 Assert rst_i with two reads in flight
//   -> all outputs 0 immediately; the following two RAM data cycles produce no data_val; normal grants resume after release.

Source files
------------

// File: rtl/data_table_rd_arbiter_pkg.sv
// Shared hash-table types and sizes.
// Used by the data-table read-port arbiter.
package data_table_rd_arbiter_pkg;

  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int RAM_DATA_WIDTH   = 32;
  localparam int N_RD_CLIENTS     = 3;
  localparam int RAM_RD_LATENCY   = 2;

  typedef logic [RAM_DATA_WIDTH-1:0] ram_data_t;

  typedef logic [$clog2(N_RD_CLIENTS)-1:0] rd_client_id_t;

endpackage

// File: rtl/data_table_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches from ptr upward, wrapping N-1 -> 0.
module rr_arbiter
  import data_table_rd_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  // First requester at or after ptr wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_table_rd_arbiter.sv
// Shares the data-table RAM read port between
// table engines; routes returns via an ID pipe.
module data_table_rd_arbiter
  import data_table_rd_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_RD_CLIENTS,
  parameter int A_WIDTH    = TABLE_ADDR_WIDTH,
  parameter int RD_LATENCY = RAM_RD_LATENCY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         req_rd_en_i,
  input  logic [N_REQ*A_WIDTH-1:0] req_rd_addr_i,
  output logic [N_REQ-1:0]         req_rd_avail_o,
  output ram_data_t                req_rd_data_o,
  output logic [N_REQ-1:0]         req_rd_data_val_o,
  input  logic                     ram_avail_i,
  output logic                     ram_rd_en_o,
  output logic [A_WIDTH-1:0]       ram_rd_addr_o,
  input  ram_data_t                ram_rd_data_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      busy;
  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      issue;
  logic [N_REQ-1:0]      ret;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         ptr_nxt;
  logic [IW-1:0]         gid;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [IW-1:0]         pipe_id [RD_LATENCY];

  assign elig = req_i & ~busy;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (IW)
  ) u_rr (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // One-hot grant to requester index.
  always_comb begin
    gid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gid = IW'(i);
    end
  end

  // Avail is forced low while reset is asserted.
  assign req_rd_avail_o =
    (ram_avail_i && !rst_i) ? grant : '0;
  assign issue         = req_rd_avail_o & req_rd_en_i;
  assign ram_rd_en_o   = |issue;
  assign ram_rd_addr_o =
    req_rd_addr_i[gid*A_WIDTH +: A_WIDTH];

  assign ptr_nxt =
    (gid == IW'(N_REQ - 1)) ? '0 : gid + 1'b1;

  // Decode the pipe's last stage into a return pulse.
  always_comb begin
    ret = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ret[i] = pipe_vld[RD_LATENCY-1] &&
               (pipe_id[RD_LATENCY-1] == IW'(i));
    end
  end

  assign req_rd_data_val_o = ret;
  assign req_rd_data_o     = ram_rd_data_i;

  // Busy set on issue, cleared the edge after return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy   <= '0;
      rr_ptr <= '0;
    end else begin
      busy <= (busy & ~ret) | issue;
      if (ram_rd_en_o) rr_ptr <= ptr_nxt;
    end
  end

  // Latency-matched shift register of {valid, id}.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= ram_rd_en_o;
      pipe_id[0]  <= gid;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

`ifndef SYNTHESIS
  a_avail_oh0: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(req_rd_avail_o));
  a_val_oh0: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(req_rd_data_val_o));
  a_no_busy_issue: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (issue & busy) == '0);
  a_val_busy: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (ret & ~busy) == '0);
  a_ret_issue: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (ret & issue) == '0);
`endif

endmodule
